// File: rtl/tage_ctr_update_ctrl_if.sv
// Bundle of update, lookup and SRAM-port signals for one TAGE counter bank.
// The slave side is the update controller. The master side is the
// surrounding pipeline together with the SRAM.
//
// Update handshake: an update transfers on a rising clk edge when upd_valid
// and upd_ready are both high. While upd_valid is high, upd_idx and
// upd_taken must stay stable until that transfer. upd_ready depends only on
// registered state, never on upd_valid.
interface tage_ctr_update_ctrl_if #(
    parameter int IDX_W = 10,
    parameter int CTR_W = 3
);
    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;

    logic             lkp_req;
    logic [IDX_W-1:0] lkp_idx;
    logic             lkp_valid;
    logic [CTR_W-1:0] lkp_ctr;

    logic             mem_en;
    logic             mem_we;
    logic [IDX_W-1:0] mem_addr;
    logic [CTR_W-1:0] mem_wdata;
    logic [CTR_W-1:0] mem_rdata;

    logic             upd_done;
    logic             busy;

    modport master (
        output upd_valid, upd_idx, upd_taken, lkp_req, lkp_idx, mem_rdata,
        input  upd_ready, lkp_valid, lkp_ctr, mem_en, mem_we, mem_addr,
               mem_wdata, upd_done, busy
    );

    modport slave (
        input  upd_valid, upd_idx, upd_taken, lkp_req, lkp_idx, mem_rdata,
        output upd_ready, lkp_valid, lkp_ctr, mem_en, mem_we, mem_addr,
               mem_wdata, upd_done, busy
    );
endinterface

// File: rtl/tage_ctr_update_ctrl.sv
// tage_ctr_update_ctrl: queues resolved-branch updates and applies them as
// read-modify-write of saturating prediction counters through a single-port
// SRAM. The lookup path always owns the port when it asks for it. Lookups
// that hit the counter being rewritten see the new value.
module tage_ctr_update_ctrl #(
    parameter int IDX_W = 10,
    parameter int CTR_W = 3,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    tage_ctr_update_ctrl_if.slave bus,
    output logic [1:0]            dbg_state
);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WAIT = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    state_t state;

    // Update FIFO storage and occupancy
    logic [IDX_W-1:0] fifo_idx   [DEPTH];
    logic             fifo_taken [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Working registers for the update in flight
    logic [IDX_W-1:0] w_idx;
    logic             w_taken;
    logic [CTR_W-1:0] w_val;

    // Lookup return pipeline
    logic             lkp_valid_q;
    logic             fwd_hit_q;
    logic [CTR_W-1:0] fwd_val_q;

    logic             push;
    logic             pop;
    logic             rd_go;
    logic             wr_go;
    logic [CTR_W-1:0] old_ctr;
    logic [CTR_W-1:0] new_ctr;
    logic             ctr_changed;

    // A full FIFO refuses pushes even when a pop happens in the same cycle,
    // so upd_ready depends only on the registered count.
    assign bus.upd_ready = (count < FULL_CNT);
    assign push          = bus.upd_valid && bus.upd_ready;
    assign pop           = (state == ST_IDLE) && (count != '0);

    // The update path uses the port only in cycles without a lookup.
    assign rd_go = (state == ST_RD) && !bus.lkp_req;
    assign wr_go = (state == ST_WR) && !bus.lkp_req;

    // Direction-based saturating step of the counter read in WAIT.
    assign old_ctr = bus.mem_rdata;
    always_comb begin
        new_ctr = old_ctr;
        if (w_taken && (old_ctr != CTR_MAX)) begin
            new_ctr = old_ctr + CTR_W'(1);
        end else if (!w_taken && (old_ctr != '0)) begin
            new_ctr = old_ctr - CTR_W'(1);
        end
    end
    assign ctr_changed = (new_ctr != old_ctr);

    // Port arbitration: the lookup has priority. Reset silences the port.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (!rst) begin
            if (bus.lkp_req) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.lkp_idx;
            end else if (rd_go) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = w_idx;
            end else if (wr_go) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = w_idx;
                bus.mem_wdata = w_val;
            end
        end
    end

    // An update retires when its write goes out, or in WAIT when the counter
    // is already saturated in the requested direction.
    assign bus.upd_done = !rst && (wr_go || ((state == ST_WAIT) && !ctr_changed));

    assign bus.busy  = (count != '0) || (state != ST_IDLE);
    assign dbg_state = state;

    // FIFO payload storage; entries are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr]   <= bus.upd_idx;
            fifo_taken[wr_ptr] <= bus.upd_taken;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // RMW sequencer: pop, read, compute, and write only if the counter moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            w_idx   <= '0;
            w_taken <= 1'b0;
            w_val   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        w_idx   <= fifo_idx[rd_ptr];
                        w_taken <= fifo_taken[rd_ptr];
                        state   <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (rd_go) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ctr_changed) begin
                        w_val <= new_ctr;
                        state <= ST_WR;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (wr_go) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Lookup return: one-cycle latency. A lookup that hits the counter being
    // rewritten (WAIT or WR) returns the new value, not the stale SRAM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lkp_valid_q <= 1'b0;
            fwd_hit_q   <= 1'b0;
            fwd_val_q   <= '0;
        end else begin
            lkp_valid_q <= bus.lkp_req;
            fwd_hit_q   <= bus.lkp_req && (bus.lkp_idx == w_idx) &&
                           ((state == ST_WAIT) || (state == ST_WR));
            fwd_val_q   <= (state == ST_WR) ? w_val : new_ctr;
        end
    end

    assign bus.lkp_valid = lkp_valid_q;
    assign bus.lkp_ctr   = !lkp_valid_q ? '0 :
                           fwd_hit_q    ? fwd_val_q : bus.mem_rdata;

    // Occupancy never exceeds the FIFO depth.
    assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);

    // Writes only come from WR, and only in cycles with no lookup.
    assert property (@(posedge clk) disable iff (rst)
                     bus.mem_we |-> ((state == ST_WR) && !bus.lkp_req));
endmodule
